// File: rtl/dso_pkg.sv
// dso_pkg: shared FSM state type and trigger constants for the capture path
package dso_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam logic TRIG_RISE = 1'b0;
    localparam logic TRIG_FALL = 1'b1;
    typedef enum logic [2:0] {IDLE, PRE_FILL, ARMED, POST_FILL, HOLD} state_t;
endpackage

// File: rtl/dso_sample_div.sv
// dso_sample_div: free-running decimation counter, one sample_en every sample_div+1 cycles
module dso_sample_div (
    input  logic        ad_clk,
    input  logic        rst,
    input  logic [15:0] sample_div,
    output logic        sample_en
);
    logic [15:0] cnt;
    assign sample_en = cnt >= sample_div;
    always_ff @(posedge ad_clk) begin
        if (rst) cnt <= '0;
        else cnt <= sample_en ? '0 : cnt + 16'd1;
    end
endmodule

// File: rtl/dso_trig_capture.sv
// dso_trig_capture: decimate ADC stream, trigger, fill circular RAM with pre-trigger history
module dso_trig_capture
    import dso_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int PRE_TRIG     = 512,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic        ad_clk,
    input  logic        rst,
    input  logic        run,
    input  logic [7:0]  ad_data,
    input  logic [15:0] sample_div,
    input  logic [7:0]  trig_level,
    input  logic        trig_edge,
    input  logic        trig_auto,
    input  logic        display_done,
    input  logic [11:0] wave_rd_addr,
    output logic        ad_buf_wr,
    output logic [11:0] ad_buf_wr_addr,
    output logic [7:0]  ad_buf_data,
    output logic [11:0] ad_buf_rd_addr,
    output logic        triggered
);
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(2 ** ADDR_W - PRE_TRIG - 1);
    state_t state, state_n;
    logic sample_en, wr_en, edge_hit, trig_hit;
    logic [ADDR_W-1:0] wr_ptr, trig_ptr, start_addr, pre_cnt, post_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0] prev_sample;

    dso_sample_div u_div (
        .ad_clk     (ad_clk),
        .rst        (rst),
        .sample_div (sample_div),
        .sample_en  (sample_en)
    );

    assign ad_buf_rd_addr = (wave_rd_addr + 12'(start_addr)) & 12'(2 ** ADDR_W - 1);

    always_comb begin
        wr_en = sample_en && (state == PRE_FILL || state == ARMED || state == POST_FILL);
        edge_hit = (trig_edge == TRIG_FALL) ? (prev_sample > trig_level && ad_data <= trig_level)
                                            : (prev_sample < trig_level && ad_data >= trig_level);
        trig_hit = state == ARMED && sample_en &&
                   (edge_hit || (trig_auto && tmo_cnt >= TW'(AUTO_TIMEOUT - 1)));
        state_n = state;
        state_n = (state == IDLE)      ? (run ? PRE_FILL : IDLE) :
                  (state == PRE_FILL)  ? ((wr_en && pre_cnt == ADDR_W'(PRE_TRIG - 1)) ? ARMED : PRE_FILL) :
                  (state == ARMED)     ? (trig_hit ? POST_FILL : ARMED) :
                  (state == POST_FILL) ? ((wr_en && post_cnt == ADDR_W'(1)) ? HOLD : POST_FILL) :
                                         ((display_done && run) ? PRE_FILL : HOLD);
    end

    always_ff @(posedge ad_clk) begin
        if (rst) begin
            state          <= IDLE;
            ad_buf_wr      <= 1'b0;
            ad_buf_wr_addr <= '0;
            ad_buf_data    <= '0;
            wr_ptr         <= '0;
            prev_sample    <= '0;
            pre_cnt        <= '0;
            post_cnt       <= '0;
            tmo_cnt        <= '0;
            trig_ptr       <= '0;
            start_addr     <= '0;
            triggered      <= 1'b0;
        end else begin
            state     <= state_n;
            ad_buf_wr <= wr_en;
            if (wr_en) begin
                ad_buf_data    <= ad_data;
                ad_buf_wr_addr <= 12'(wr_ptr);
                wr_ptr         <= wr_ptr + ADDR_W'(1);
                prev_sample    <= ad_data;
            end
            pre_cnt <= (state == PRE_FILL) ? pre_cnt + ADDR_W'(wr_en) : '0;
            tmo_cnt <= (state != ARMED) ? '0 :
                       (sample_en && tmo_cnt != TW'(AUTO_TIMEOUT)) ? tmo_cnt + TW'(1) : tmo_cnt;
            if (trig_hit) begin
                trig_ptr  <= wr_ptr;
                post_cnt  <= POST_INIT;
                triggered <= 1'b1;
            end else if (state == POST_FILL && wr_en) begin
                post_cnt <= post_cnt - ADDR_W'(1);
            end
            if (state == POST_FILL && state_n == HOLD) start_addr <= trig_ptr - ADDR_W'(PRE_TRIG);
            if (state == HOLD && state_n == PRE_FILL) triggered <= 1'b0;
        end
    end
endmodule

// File: doc/dso_trig_capture.md
Name: dso_trig_capture

Overview:
- Upstream acquisition stage for the waveform display. Decimates the 8-bit ADC stream, detects a level/edge trigger and fills the 1024-entry sample RAM circularly with a fixed pre-trigger depth.
- Holds the captured frame until the display reports a completed frame, then re-arms.
- Provides the trigger-aligned RAM read address, so the display column 0 is always the oldest pre-trigger sample.

Parameters:
- ADDR_W, 10, log2 of capture RAM depth (1024 samples).
- PRE_TRIG, 512, samples kept before the trigger point; must be 1..2**ADDR_W-2.
- AUTO_TIMEOUT, 65535, decimated samples to wait in ARMED before a forced trigger in auto mode.

Ports:
- ad_clk  in  1  sole clock (ADC clock).
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = acquire continuously; 0 = freeze the current frame after it completes.
- ad_data  in  8  raw ADC sample, valid every ad_clk.
- sample_div  in  16  decimation; take one sample every sample_div+1 cycles.
- trig_level  in  8  trigger threshold.
- trig_edge  in  1  0 = rising, 1 = falling.
- trig_auto  in  1  1 = auto mode (timeout forces trigger); 0 = normal mode.
- display_done  in  1  one-cycle pulse, already synchronised to ad_clk: display finished drawing a frame.
- wave_rd_addr  in  12  display column read index.
- ad_buf_wr  out  1  RAM write enable.
- ad_buf_wr_addr  out  12  RAM write address; bits [11:10] are always 0.
- ad_buf_data  out  8  RAM write data.
- ad_buf_rd_addr  out  12  trigger-aligned RAM read address.
- triggered  out  1  1 from trigger detection until re-arm (status/LED).

Behaviour:
- Reset values: all outputs 0; internal start_addr = 0; prev_sample = 0; state = IDLE; decimation counter = 0.
- Decimator: counter runs 0..sample_div and wraps. sample_en pulses at the wrap. sample_div = 0 gives sample_en every cycle. The counter runs in every state.
- Write path: in PRE_FILL, ARMED and POST_FILL, each sample_en registers ad_data into ad_buf_data, asserts ad_buf_wr for exactly 1 cycle (latency 1 cycle from sample_en) at the current wr_ptr, then wr_ptr increments mod 1024.
  - ad_buf_wr_addr = {2'b00, wr_ptr} as used for that write.
  - prev_sample updates to each written sample.
- State machine:
  - IDLE: go to PRE_FILL when run = 1. pre_cnt = 0.
  - PRE_FILL: count written samples. After PRE_TRIG writes, go to ARMED. Guarantees valid pre-trigger history.
  - ARMED: on sample_en, trigger condition uses the new sample s and prev_sample:
    - rising: prev_sample < trig_level && s >= trig_level.
    - falling: prev_sample > trig_level && s <= trig_level.
    - On trigger: s is still written; trig_ptr <= that write's address; post_cnt <= 2**ADDR_W - PRE_TRIG - 1; triggered <= 1; go to POST_FILL.
    - Auto mode: a timeout counter counts sample_en in ARMED. When it reaches AUTO_TIMEOUT, force the trigger identically on that sample. The counter clears on entry to ARMED.
    - trig_level, trig_edge and trig_auto changes take effect immediately.
  - POST_FILL: each write decrements post_cnt. The write made with post_cnt = 1 is the last; next cycle go to HOLD with start_addr <= (trig_ptr - PRE_TRIG) mod 1024.
  - HOLD: no writes. On display_done && run, go to PRE_FILL and clear triggered.
    - run = 0: stay in HOLD indefinitely; display_done is ignored.
    - display_done in any other state is ignored.
- Read mapping (combinational): ad_buf_rd_addr = {2'b00, (wave_rd_addr[9:0] + start_addr) mod 1024}. start_addr changes only on POST_FILL→HOLD, so it is stable while the display reads the frame.
- run deasserted during PRE_FILL, ARMED or POST_FILL: the capture completes normally, then freezes in HOLD.
- Reset mid-capture: return to IDLE next cycle, any in-flight write is dropped (ad_buf_wr = 0), RAM contents are undefined.
- Frame content: exactly 1024 consecutive decimated samples, trigger sample at display index PRE_TRIG.

Decomposition:
- Shared package dso_pkg: state enum (IDLE, PRE_FILL, ARMED, POST_FILL, HOLD), ADDR_W default, edge-select constants TRIG_RISE = 0 and TRIG_FALL = 1.
- One natural sub-module: dso_sample_div (decimation counter producing sample_en). Trigger compare and FSM stay in the top.

Test Plan:
- Ramp with rising trigger: ad_data ramps 0..255 repeating, sample_div = 0, trig_level = 100, trig_edge = 0, run = 1 → first trigger write has data 100; triggered = 1; HOLD reached; reading wave_rd_addr 512 returns 100 and wave_rd_addr 511 returns 99.
- Falling edge with decimation: descending ramp, sample_div = 3, trig_level = 50 → ad_buf_wr pulses exactly every 4 cycles; trigger sample = 50 at display index 512.
- Auto timeout: constant ad_data = 20, trig_level = 100, trig_auto = 1, AUTO_TIMEOUT = 16 → forced trigger on the 16th armed sample, HOLD after 511 more writes.
  - Same stimulus with trig_auto = 0 → stays ARMED and keeps writing, triggered = 0.
- HOLD handshake: in HOLD, pulse display_done with run = 1 → PRE_FILL next cycle, triggered = 0.
  - With run = 0 → remains HOLD, ad_buf_wr stays 0 for 5000 cycles.
- Wrap-around: trigger when wr_ptr = 100 → start_addr = 612; wave_rd_addr = 500 maps to ad_buf_rd_addr = 88.
- Reset mid-capture: assert rst during POST_FILL → next cycle state IDLE and all outputs 0.
  - Deassert with run = 1 → PRE_FILL restarts at wr_ptr = 0.
